cc_demux18: RTL and testbench

- Write-side counterpart of the team's 8-to-1 slot multiplexer. It accepts a stream of DATAWIDTH-bit words over a valid/ready handshake and writes them into eight output slot registers in order, slot 1 through slot 8.
- When all eight slots are written, the completed frame is presented to the downstream reader. The reader then selects slots with its own mux and acknowledges the frame.
- Sits between a serial/word producer (for example a UART or SPI front end) and the slot-select read path.

---
 rtl/cc_demux18_pkg.sv | 13 +
 rtl/cc_demux18_slotreg.sv | 25 ++
 rtl/cc_demux18.sv | 129 ++++++++++++
 tb/tb_cc_demux18.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cc_demux18_pkg.sv
// Shared definitions for the cc_demux18 word-to-slot demultiplexer.
// State encodings, slot count and last-slot index used by the top and the bench.
package cc_demux18_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  localparam int          SLOT_COUNT = 8;
  localparam logic [2:0]  LAST_SLOT  = 3'd7;

endpackage

// File: rtl/cc_demux18_slotreg.sv
// One slot of the demux: a DATAWIDTH-bit register with write enable.
// Asynchronous active-low reset clears it to zero.
module cc_demux18_slotreg #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [DATAWIDTH-1:0] i_d,
  output logic [DATAWIDTH-1:0] o_q
);

  logic [DATAWIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/cc_demux18.sv
// Word stream to eight slot registers; presents a full frame until the reader acks it.
// Optional macro CC_DEMUX18_FILLCOUNT_EN adds a registered 4-bit accepted-word counter.
module cc_demux18
  import cc_demux18_pkg::*;
#(
  parameter int DEMUX18_SELECTWIDTH = 3,
  parameter int DEMUX18_DATAWIDTH   = 8
) (
  input  logic                           CC_DEMUX18_CLOCK_50,
  input  logic                           CC_DEMUX18_RESET_InLow,
  input  logic [DEMUX18_DATAWIDTH-1:0]   CC_DEMUX18_data_InBUS,
  input  logic                           CC_DEMUX18_valid_In,
  output logic                           CC_DEMUX18_ready_Out,
  input  logic                           CC_DEMUX18_clear_In,
  input  logic                           CC_DEMUX18_frameAck_In,
  output logic                           CC_DEMUX18_frameValid_Out,
  output logic [DEMUX18_SELECTWIDTH-1:0] CC_DEMUX18_select_OutBUS,
  output logic [DEMUX18_DATAWIDTH-1:0]   CC_DEMUX18_data1_OutBUS,
  output logic [DEMUX18_DATAWIDTH-1:0]   CC_DEMUX18_data2_OutBUS,
  output logic [DEMUX18_DATAWIDTH-1:0]   CC_DEMUX18_data3_OutBUS,
  output logic [DEMUX18_DATAWIDTH-1:0]   CC_DEMUX18_data4_OutBUS,
  output logic [DEMUX18_DATAWIDTH-1:0]   CC_DEMUX18_data5_OutBUS,
  output logic [DEMUX18_DATAWIDTH-1:0]   CC_DEMUX18_data6_OutBUS,
  output logic [DEMUX18_DATAWIDTH-1:0]   CC_DEMUX18_data7_OutBUS,
  output logic [DEMUX18_DATAWIDTH-1:0]   CC_DEMUX18_data8_OutBUS,
`ifdef CC_DEMUX18_FILLCOUNT_EN
  output logic [3:0]                     CC_DEMUX18_fillCount_OutBUS,
`endif
  output logic                           CC_DEMUX18_dbgState_Out
);

  // Handshake: a word transfers on a rising edge where valid=1 and ready=1 and
  // clear=0; ready depends only on the state register, and the producer must
  // hold data stable while valid=1 and ready=0.

  state_t                      r_state;
  state_t                      w_next_state;
  logic   [2:0]                r_ptr;
  logic                        w_ready;
  logic                        w_frame_valid;
  logic                        w_accept;
  logic                        w_ack_full;
  logic [DEMUX18_DATAWIDTH-1:0] w_slot [SLOT_COUNT];

  assign w_accept   = CC_DEMUX18_valid_In && w_ready && !CC_DEMUX18_clear_In;
  assign w_ack_full = (r_state == ST_FULL) && CC_DEMUX18_frameAck_In;

  always_ff @(posedge CC_DEMUX18_CLOCK_50 or negedge CC_DEMUX18_RESET_InLow) begin
    if (!CC_DEMUX18_RESET_InLow) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (CC_DEMUX18_clear_In) begin
      w_next_state = ST_FILL;
    end else if (w_ack_full) begin
      w_next_state = ST_FILL;
    end else if (w_accept && (r_ptr == LAST_SLOT)) begin
      w_next_state = ST_FULL;
    end
  end

  always_comb begin
    w_ready       = 1'b0;
    w_frame_valid = 1'b0;
    case (r_state)
      ST_FILL: w_ready       = 1'b1;
      ST_FULL: w_frame_valid = 1'b1;
      default: w_ready       = 1'b0;
    endcase
  end

  // Pointer wraps to 0 on the eighth accept, so it is already 0 in FULL.
  always_ff @(posedge CC_DEMUX18_CLOCK_50 or negedge CC_DEMUX18_RESET_InLow) begin
    if (!CC_DEMUX18_RESET_InLow) begin
      r_ptr <= 3'd0;
    end else if (CC_DEMUX18_clear_In) begin
      r_ptr <= 3'd0;
    end else if (w_accept) begin
      r_ptr <= r_ptr + 3'd1;
    end
  end

  for (genvar gi = 0; gi < SLOT_COUNT; gi++) begin : g_slot
    cc_demux18_slotreg #(
      .DATAWIDTH (DEMUX18_DATAWIDTH)
    ) u_slot (
      .i_clk   (CC_DEMUX18_CLOCK_50),
      .i_rst_n (CC_DEMUX18_RESET_InLow),
      .i_en    (w_accept && (r_ptr == 3'(gi))),
      .i_d     (CC_DEMUX18_data_InBUS),
      .o_q     (w_slot[gi])
    );
  end

`ifdef CC_DEMUX18_FILLCOUNT_EN
  logic [3:0] r_fill_count;

  always_ff @(posedge CC_DEMUX18_CLOCK_50 or negedge CC_DEMUX18_RESET_InLow) begin
    if (!CC_DEMUX18_RESET_InLow) begin
      r_fill_count <= 4'd0;
    end else if (CC_DEMUX18_clear_In || w_ack_full) begin
      r_fill_count <= 4'd0;
    end else if (w_accept) begin
      r_fill_count <= r_fill_count + 4'd1;
    end
  end

  assign CC_DEMUX18_fillCount_OutBUS = r_fill_count;
`endif

  assign CC_DEMUX18_ready_Out      = w_ready;
  assign CC_DEMUX18_frameValid_Out = w_frame_valid;
  assign CC_DEMUX18_select_OutBUS  = (DEMUX18_SELECTWIDTH)'(r_ptr);
  assign CC_DEMUX18_dbgState_Out   = r_state;
  assign CC_DEMUX18_data1_OutBUS   = w_slot[0];
  assign CC_DEMUX18_data2_OutBUS   = w_slot[1];
  assign CC_DEMUX18_data3_OutBUS   = w_slot[2];
  assign CC_DEMUX18_data4_OutBUS   = w_slot[3];
  assign CC_DEMUX18_data5_OutBUS   = w_slot[4];
  assign CC_DEMUX18_data6_OutBUS   = w_slot[5];
  assign CC_DEMUX18_data7_OutBUS   = w_slot[6];
  assign CC_DEMUX18_data8_OutBUS   = w_slot[7];

endmodule

// File: tb/tb_cc_demux18.sv
// Self-checking bench for cc_demux18: directed words, frame scoreboard on frameValid rise.
// Build with +define+CC_DEMUX18_FILLCOUNT_EN to also check the fill counter.
module tb_cc_demux18;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       clear_in;
  logic       ack_in;
  logic       fv_out;
  logic [2:0] sel_out;
  logic [7:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic       dbg_state;
`ifdef CC_DEMUX18_FILLCOUNT_EN
  logic [3:0] fill_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic        prev_fv;

  cc_demux18 #(
    .DEMUX18_SELECTWIDTH (3),
    .DEMUX18_DATAWIDTH   (8)
  ) dut (
    .CC_DEMUX18_CLOCK_50       (clk),
    .CC_DEMUX18_RESET_InLow    (rst_n),
    .CC_DEMUX18_data_InBUS     (data_in),
    .CC_DEMUX18_valid_In       (valid_in),
    .CC_DEMUX18_ready_Out      (ready_out),
    .CC_DEMUX18_clear_In       (clear_in),
    .CC_DEMUX18_frameAck_In    (ack_in),
    .CC_DEMUX18_frameValid_Out (fv_out),
    .CC_DEMUX18_select_OutBUS  (sel_out),
    .CC_DEMUX18_data1_OutBUS   (d1),
    .CC_DEMUX18_data2_OutBUS   (d2),
    .CC_DEMUX18_data3_OutBUS   (d3),
    .CC_DEMUX18_data4_OutBUS   (d4),
    .CC_DEMUX18_data5_OutBUS   (d5),
    .CC_DEMUX18_data6_OutBUS   (d6),
    .CC_DEMUX18_data7_OutBUS   (d7),
    .CC_DEMUX18_data8_OutBUS   (d8),
`ifdef CC_DEMUX18_FILLCOUNT_EN
    .CC_DEMUX18_fillCount_OutBUS (fill_count),
`endif
    .CC_DEMUX18_dbgState_Out   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] slots();
    return {d8, d7, d6, d5, d4, d3, d2, d1};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each rising frameValid must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && fv_out && !prev_fv) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", slots(), 64'h0);
      end else begin
        chk("frame_data", slots(), exp_q.pop_front());
        chk("frame_select", {61'd0, sel_out}, 64'd0);
        chk("frame_ready", {63'd0, ready_out}, 64'd0);
      end
    end
    prev_fv <= fv_out;
  end

  // Driver: present a word and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d);
    int n = 0;
    valid_in = 1'b1;
    data_in  = d;
    while (!ready_out && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic send_gapped(input logic [7:0] d, input logic [2:0] exp_sel);
    valid_in = 1'b1;
    data_in  = d;
    @(posedge clk); #1;
    valid_in = 1'b0;
    data_in  = 8'hEE;
    chk("gap_sel_accept", {61'd0, sel_out}, {61'd0, exp_sel});
    @(posedge clk); #1;
    chk("gap_sel_idle", {61'd0, sel_out}, {61'd0, exp_sel});
  endtask

  task automatic pulse_ack();
    ack_in = 1'b1;
    @(posedge clk); #1;
    ack_in = 1'b0;
  endtask

  initial begin
    prev_fv  = 1'b0;
    rst_n    = 1'b0;
    data_in  = 8'h00;
    valid_in = 1'b0;
    clear_in = 1'b0;
    ack_in   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_slots", slots(), 64'h0);
    chk("rst_select", {61'd0, sel_out}, 64'd0);
    chk("rst_ready", {63'd0, ready_out}, 64'd1);
    chk("rst_fv", {63'd0, fv_out}, 64'd0);
    chk("rst_state", {63'd0, dbg_state}, 64'd0);
`ifdef CC_DEMUX18_FILLCOUNT_EN
    chk("rst_fill", {60'd0, fill_count}, 64'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_slots", slots(), 64'h0);
    chk("idle_select", {61'd0, sel_out}, 64'd0);

    // Full frame, back to back
    exp_q.push_back(64'h8877665544332211);
    for (int i = 1; i <= 8; i++) begin
      send(8'((i << 4) | i));
      chk("frame_sel_step", {61'd0, sel_out}, 64'(i % 8));
    end
    chk("full_fv", {63'd0, fv_out}, 64'd1);
    chk("full_ready", {63'd0, ready_out}, 64'd0);
    chk("full_state", {63'd0, dbg_state}, 64'd1);
`ifdef CC_DEMUX18_FILLCOUNT_EN
    chk("full_fill", {60'd0, fill_count}, 64'd8);
`endif

    // Backpressure in FULL, then ack
    valid_in = 1'b1;
    data_in  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_slots", slots(), 64'h8877665544332211);
      chk("bp_ready", {63'd0, ready_out}, 64'd0);
    end
    pulse_ack();
    valid_in = 1'b0;
    chk("ack_ready", {63'd0, ready_out}, 64'd1);
    chk("ack_fv", {63'd0, fv_out}, 64'd0);
    chk("ack_slots", slots(), 64'h8877665544332211);
`ifdef CC_DEMUX18_FILLCOUNT_EN
    chk("ack_fill", {60'd0, fill_count}, 64'd0);
`endif
    send(8'hA5);
    chk("a5_slots", slots(), 64'h88776655443322A5);
    chk("a5_select", {61'd0, sel_out}, 64'd1);

    // Gapped input finishes the frame
    exp_q.push_back(64'hB8B7B6B5B4B3B2A5);
    for (int i = 2; i <= 8; i++) begin
      send_gapped(8'(8'hB0 + i), 3'(i % 8));
    end
    chk("gap_fv", {63'd0, fv_out}, 64'd1);
    pulse_ack();

    // Ack in FILL is ignored
    pulse_ack();
    chk("fill_ack_ready", {63'd0, ready_out}, 64'd1);
    chk("fill_ack_sel", {61'd0, sel_out}, 64'd0);

    // Clear mid-frame drops the coincident word
    for (int i = 1; i <= 5; i++) send(8'(8'hC0 + i));
    chk("pre_clear_sel", {61'd0, sel_out}, 64'd5);
    clear_in = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h5A;
    @(posedge clk); #1;
    clear_in = 1'b0;
    valid_in = 1'b0;
    chk("clear_sel", {61'd0, sel_out}, 64'd0);
    chk("clear_fv", {63'd0, fv_out}, 64'd0);
    chk("clear_slots", slots(), 64'hB8B7B6C5C4C3C2C1);
`ifdef CC_DEMUX18_FILLCOUNT_EN
    chk("clear_fill", {60'd0, fill_count}, 64'd0);
`endif
    send(8'h3C);
    chk("post_clear_slots", slots(), 64'hB8B7B6C5C4C3C23C);
    exp_q.push_back(64'hD8D7D6D5D4D3D23C);
    for (int i = 2; i <= 8; i++) send(8'(8'hD0 + i));
    pulse_ack();

    // Async reset between edges
    for (int i = 1; i <= 3; i++) send(8'(8'hE0 + i));
    chk("pre_rst_sel", {61'd0, sel_out}, 64'd3);
`ifdef CC_DEMUX18_FILLCOUNT_EN
    chk("pre_rst_fill", {60'd0, fill_count}, 64'd3);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_slots", slots(), 64'h0);
    chk("arst_sel", {61'd0, sel_out}, 64'd0);
    chk("arst_ready", {63'd0, ready_out}, 64'd1);
`ifdef CC_DEMUX18_FILLCOUNT_EN
    chk("arst_fill", {60'd0, fill_count}, 64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    chk("frames_left", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
